// File: rtl/dtree_pkg.sv
// Shared encodings for the dtree scheduler slice:
// FSM states, slot states and dtree result widths.
package dtree_pkg;

  localparam int LVL_W  = 2;
  localparam int PATH_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_FULL,
    SLOT_SERVING
  } slot_t;

endpackage

// File: rtl/dtree_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request
// found scanning upward from last+1, wrapping.
module rr_arbiter
  import dtree_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_WIDTH-1:0] last,
  output logic [CH_WIDTH-1:0] grant,
  output logic                any
);

  logic [CH_WIDTH-1:0] k;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      k = CH_WIDTH'((int'(last) + i) % CHANNELS);
      if (!any && req[k]) begin
        grant = k;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtree_scheduler.sv
// Time-shares one dtree classifier among channels:
// per-channel slots, RR grant, replay, watchdog.
module dtree_scheduler
  import dtree_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int FEATURES   = 3,
  parameter int IN_WIDTH   = 10,
  parameter int MAX_PASSES = 8,
  localparam int CH_WIDTH  = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_valid,
  output logic [CHANNELS-1:0]          ch_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] ch_sample,
  input  logic                         dt_ready,
  output logic                         dt_valid,
  output logic [IN_WIDTH-1:0]          dt_sample,
  input  logic [LVL_W-1:0]             dt_level,
  input  logic [PATH_W-1:0]            dt_path,
  input  logic                         dt_out_valid,
  output logic                         dt_reset,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [CH_WIDTH-1:0]          res_channel,
  output logic [LVL_W-1:0]             res_level,
  output logic [PATH_W-1:0]            res_path,
  output logic                         res_timeout,
  output logic                         busy
);

  localparam int IDX_W =
    (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int PASS_W = $clog2(MAX_PASSES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(FEATURES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST =
    PASS_W'(MAX_PASSES - 1);

  state_t              state;
  slot_t               slot_st [CHANNELS];
  logic [IN_WIDTH-1:0] slot    [CHANNELS][FEATURES];
  logic [IDX_W-1:0]    wr_cnt  [CHANNELS];
  logic [CH_WIDTH-1:0] cur;
  logic [CH_WIDTH-1:0] last;
  logic [CH_WIDTH-1:0] grant;
  logic [IDX_W-1:0]    idx;
  logic [PASS_W-1:0]   passes;
  logic [CHANNELS-1:0] full;
  logic                any_full;
  logic                abort;

  always_comb begin
    full     = '0;
    ch_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]     = (slot_st[c] == SLOT_FULL);
      ch_ready[c] = (slot_st[c] == SLOT_EMPTY);
    end
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req   (full),
    .last  (last),
    .grant (grant),
    .any   (any_full)
  );

  assign dt_valid    = (state == S_ISSUE);
  assign dt_sample   = dt_valid ? slot[cur][idx] : '0;
  assign res_valid   = (state == S_REPORT);
  assign res_channel = cur;
  assign busy        = (state != S_IDLE);
  assign dt_reset    = reset | abort;

  // Sample storage carries no reset; slot state gates it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (ch_valid[c] && ch_ready[c])
        slot[c][wr_cnt[c]] <=
          ch_sample[c*IN_WIDTH +: IN_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      last        <= CH_WIDTH'(CHANNELS - 1);
      idx         <= '0;
      passes      <= '0;
      abort       <= 1'b0;
      res_level   <= '0;
      res_path    <= '0;
      res_timeout <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        slot_st[c] <= SLOT_EMPTY;
        wr_cnt[c]  <= '0;
      end
    end else begin
      abort <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_valid[c] && slot_st[c] == SLOT_EMPTY) begin
          if (wr_cnt[c] == IDX_LAST) begin
            slot_st[c] <= SLOT_FULL;
            wr_cnt[c]  <= '0;
          end else begin
            wr_cnt[c] <= wr_cnt[c] + 1'b1;
          end
        end
      end
      unique case (state)
        S_IDLE: begin
          if (any_full) begin
            cur            <= grant;
            slot_st[grant] <= SLOT_SERVING;
            idx            <= '0;
            passes         <= '0;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A classification wins over any feature handshake.
          if (dt_out_valid) begin
            res_level   <= dt_level;
            res_path    <= dt_path;
            res_timeout <= 1'b0;
            state       <= S_REPORT;
          end else if (dt_ready) begin
            if (idx == IDX_LAST) begin
              idx    <= '0;
              passes <= passes + 1'b1;
              if (passes == PASS_LAST) begin
                res_level   <= '0;
                res_path    <= '0;
                res_timeout <= 1'b1;
                abort       <= 1'b1;
                state       <= S_REPORT;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            slot_st[cur] <= SLOT_EMPTY;
            last         <= cur;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_scheduler.sv
// Bench for dtree_scheduler: random vectors and dtree
// timing against a round-robin / replay reference.
`timescale 1ns/1ps
module tb_dtree_scheduler;

  localparam int CH = 4;
  localparam int F  = 3;
  localparam int W  = 10;
  localparam int MP = 2;
  localparam int CW = $clog2(CH);

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] ch_valid;
  logic [CH-1:0] ch_ready;
  logic [CH*W-1:0] ch_sample;
  logic          dt_ready;
  logic          dt_valid;
  logic [W-1:0]  dt_sample;
  logic [1:0]    dt_level;
  logic [1:0]    dt_path;
  logic          dt_out_valid;
  logic          dt_reset;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_channel;
  logic [1:0]    res_level;
  logic [1:0]    res_path;
  logic          res_timeout;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference state: stored vectors, full slots, last served.
  int          vec [CH][F];
  bit [CH-1:0] full_m;
  int          last_srv;
  int          served [$];

  always #5 clk = ~clk;

  dtree_scheduler #(
    .CHANNELS   (CH),
    .FEATURES   (F),
    .IN_WIDTH   (W),
    .MAX_PASSES (MP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_sample    (ch_sample),
    .dt_ready     (dt_ready),
    .dt_valid     (dt_valid),
    .dt_sample    (dt_sample),
    .dt_level     (dt_level),
    .dt_path      (dt_path),
    .dt_out_valid (dt_out_valid),
    .dt_reset     (dt_reset),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_channel  (res_channel),
    .res_level    (res_level),
    .res_path     (res_path),
    .res_timeout  (res_timeout),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_ch();
    for (int i = 1; i <= CH; i++)
      if (full_m[(last_srv + i) % CH])
        return (last_srv + i) % CH;
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    full_m   = '0;
    last_srv = CH - 1;
  endtask

  task automatic load(input bit [CH-1:0] mask,
                      input bit fixed);
    logic [CH*W-1:0] s;
    for (int j = 0; j < F; j++) begin
      s = '0;
      for (int c = 0; c < CH; c++) begin
        if (mask[c]) begin
          vec[c][j] = fixed ? 100 * (j + 1)
                            : int'($urandom_range(0, 1023));
          s[c*W +: W] = W'(vec[c][j]);
        end
      end
      checks++;
      if ((ch_ready & mask) !== mask) begin
        failures++;
        $display("FAIL load_ready got=%b need=%b",
                 ch_ready & mask, mask);
      end
      ch_valid  = mask;
      ch_sample = s;
      tick();
    end
    ch_valid = '0;
    checks++;
    if ((ch_ready & mask) !== '0) begin
      failures++;
      $display("FAIL load_full got=%b need=0",
               ch_ready & mask);
    end
    full_m |= mask;
  endtask

  // k = features presented before answer (0: never answer)
  task automatic serve(input int k, input int mode,
                       input int stall, input int fill,
                       input logic [1:0] lv,
                       input logic [1:0] pt);
    int ch, acc, cyc, n;
    bit r, answered, to;
    bit [3:0] pat;
    logic [4:0] exp5;
    pat = 4'b1001;
    ch  = next_ch();
    n   = 0;
    while (dt_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (dt_valid !== 1'b1) begin
      failures++;
      $display("FAIL issue_start got=%b need=1", dt_valid);
      return;
    end
    acc = 0;
    cyc = 0;
    answered = 1'b0;
    while (cyc < 200) begin
      checks++;
      if (dt_sample !== W'(vec[ch][acc % F])) begin
        failures++;
        $display("FAIL dt_sample ch=%0d n=%0d got=%0d need=%0d",
                 ch, acc, dt_sample, vec[ch][acc % F]);
      end
      r = (mode == 0) ? 1'b1 :
          (mode == 1) ? pat[cyc % 4] :
          1'($urandom_range(0, 1));
      dt_ready = r;
      if (k != 0 && acc == k - 1) begin
        dt_level     = lv;
        dt_path      = pt;
        dt_out_valid = 1'b1;
        tick();
        dt_out_valid = 1'b0;
        answered     = 1'b1;
        break;
      end
      tick();
      cyc++;
      if (r) acc++;
      if (k == 0 && acc == F * MP) break;
      checks++;
      if (dt_valid !== 1'b1) begin
        failures++;
        $display("FAIL issue_drop got=%b need=1", dt_valid);
        break;
      end
    end
    dt_ready = 1'b0;
    checks++;
    if (!(answered || (k == 0 && acc == F * MP))) begin
      failures++;
      $display("FAIL issue_end accepted=%0d need=%0d",
               acc, (k == 0) ? F * MP : k);
    end
    to   = (k == 0);
    exp5 = to ? 5'b00001 : {lv, pt, 1'b0};
    checks++;
    if (dt_reset !== to) begin
      failures++;
      $display("FAIL abort_pulse got=%b need=%b",
               dt_reset, to);
    end
    checks++;
    if (res_valid !== 1'b1 || dt_valid !== 1'b0 ||
        busy !== 1'b1) begin
      failures++;
      $display("FAIL report_state got=%b%b%b need=101",
               res_valid, dt_valid, busy);
    end
    checks++;
    if (res_channel !== CW'(ch)) begin
      failures++;
      $display("FAIL res_channel got=%0d need=%0d",
               res_channel, ch);
    end
    checks++;
    if ({res_level, res_path, res_timeout} !== exp5) begin
      failures++;
      $display("FAIL res_fields got=%b need=%b",
               {res_level, res_path, res_timeout}, exp5);
    end
    checks++;
    if (ch_ready[ch] !== 1'b0) begin
      failures++;
      $display("FAIL serving_ready ch=%0d got=1 need=0", ch);
    end
    res_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      ch_valid = '0;
      if (fill >= 0 && s < F) begin
        vec[fill][s] = int'($urandom_range(0, 1023));
        ch_sample = '0;
        ch_sample[fill*W +: W] = W'(vec[fill][s]);
        ch_valid[fill] = 1'b1;
      end
      dt_out_valid = 1'b1;
      dt_level     = ~lv;
      dt_path      = ~pt;
      tick();
      checks++;
      if (res_valid !== 1'b1 || dt_valid !== 1'b0 ||
          res_channel !== CW'(ch) || dt_reset !== 1'b0 ||
          {res_level, res_path, res_timeout} !== exp5) begin
        failures++;
        $display("FAIL stall_hold s=%0d got=%b%b%0d%b/%b need=1001/%b",
                 s, res_valid, dt_valid, res_channel, dt_reset,
                 {res_level, res_path, res_timeout}, exp5);
      end
    end
    ch_valid     = '0;
    dt_out_valid = 1'b0;
    if (fill >= 0) begin
      checks++;
      if (ch_ready[fill] !== 1'b0) begin
        failures++;
        $display("FAIL fill_full ch=%0d got=1 need=0", fill);
      end
      full_m[fill] = 1'b1;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 ||
        dt_valid !== 1'b0 || dt_reset !== 1'b0 ||
        ch_ready[ch] !== 1'b1) begin
      failures++;
      $display("FAIL handshake got=%b%b%b%b%b need=00001",
               res_valid, busy, dt_valid, dt_reset,
               ch_ready[ch]);
    end
    full_m[ch] = 1'b0;
    last_srv   = ch;
    served.push_back(ch);
  endtask

  task automatic test_reset();
    ch_valid     = '0;
    ch_sample    = '0;
    dt_ready     = 1'b0;
    dt_out_valid = 1'b0;
    dt_level     = '0;
    dt_path      = '0;
    res_ready    = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    checks++;
    if (dt_reset !== 1'b1) begin
      failures++;
      $display("FAIL reset_dt_reset got=%b need=1", dt_reset);
    end
    checks++;
    if (ch_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_ch_ready got=%b need=1111", ch_ready);
    end
    checks++;
    if ({dt_valid, dt_sample, res_valid, res_channel,
         res_level, res_path, res_timeout, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b%0d%b%0d%0d%0d%b%b need=0",
               dt_valid, dt_sample, res_valid, res_channel,
               res_level, res_path, res_timeout, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dt_reset !== 1'b0) begin
      failures++;
      $display("FAIL release_dt_reset got=%b need=0", dt_reset);
    end
    full_m   = '0;
    last_srv = CH - 1;
  endtask

  task automatic test_single();
    load(4'b0001, 1'b1);
    checks++;
    if (dt_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL grant_latency got=%b%b need=00",
               dt_valid, busy);
    end
    tick();
    checks++;
    if (dt_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_issue got=%b need=1", dt_valid);
    end
    serve(F * MP, 0, 2, -1, 2'd2, 2'b01);
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    served.delete();
    load(4'hF, 1'b0);
    serve(int'($urandom_range(1, F * MP)), 2,
          int'($urandom_range(0, 2)), -1,
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    load(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++)
      serve(int'($urandom_range(1, F * MP)), 2,
            int'($urandom_range(0, 2)), -1,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    checks++;
    if (served.size() !== 5) begin
      failures++;
      $display("FAIL rr_count got=%0d need=5", served.size());
    end
    for (int i = 0; i < served.size() && i < 5; i++) begin
      checks++;
      if (served[i] !== exp_order[i]) begin
        failures++;
        $display("FAIL rr_order i=%0d got=%0d need=%0d",
                 i, served[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    load(4'b0100, 1'b0);
    serve(F * MP, 1, 1, -1, 2'd1, 2'd3);
    load(4'b0010, 1'b0);
    serve(0, 1, 1, -1, 2'd0, 2'd0);
  endtask

  task automatic test_timeout();
    load(4'b1000, 1'b0);
    serve(0, 0, 2, -1, 2'd3, 2'd3);
  endtask

  task automatic test_result_stall();
    load(4'b0001, 1'b0);
    serve(4, 0, 10, 1, 2'd1, 2'd2);
    serve(int'($urandom_range(1, F * MP)), 2, 0, -1,
          2'd3, 2'd0);
  endtask

  task automatic test_reset_mid();
    load(4'b0100, 1'b0);
    tick();
    checks++;
    if (dt_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue got=%b need=1", dt_valid);
    end
    dt_ready  = 1'b1;
    ch_valid  = 4'b1000;
    ch_sample = '1;
    tick();
    tick();
    ch_valid = '0;
    reset    = 1'b1;
    #1;
    checks++;
    if (dt_reset !== 1'b1) begin
      failures++;
      $display("FAIL mid_dt_reset got=%b need=1", dt_reset);
    end
    tick();
    reset    = 1'b0;
    dt_ready = 1'b0;
    checks++;
    if (ch_ready !== 4'hF ||
        {dt_valid, dt_sample, res_valid, res_channel,
         res_level, res_path, res_timeout, busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outs rdy=%b v=%b s=%0d r=%b b=%b",
               ch_ready, dt_valid, dt_sample, res_valid, busy);
    end
    full_m   = '0;
    last_srv = CH - 1;
    dt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0 || dt_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle got=%b%b need=00",
                 res_valid, dt_valid);
      end
    end
    dt_ready = 1'b0;
    load(4'b1000, 1'b0);
    serve(int'($urandom_range(1, F * MP)), 0, 0, -1,
          2'd2, 2'd1);
  endtask

  task automatic test_random();
    int guard;
    apply_reset();
    for (int it = 0; it < 6; it++) begin
      load(4'($urandom_range(1, 15)), 1'b0);
      guard = 0;
      while (full_m != '0 && guard < CH) begin
        serve(int'($urandom_range(0, F * MP)),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), -1,
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)));
        guard++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_result_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d",
             checks, failures);
    $fatal(1);
  end

endmodule
